uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART_TX transmitter among N byte producers.
- Each producer uses a Req/Ack handshake. The block drives XMitGo/TxData and tracks TxEmpty for each byte.
- A per-requester Lock keeps the grant for multi-byte messages.
- Sits between the producers (TXDriver-style message sources) and the UART_TX instance.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the producer-side Req/Ack/Data/Lock signals and the UART_TX-side signals shared by the arbiter.
// The master modport is the side that drives the requests and TxEmpty; the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]   Req;
  logic [N-1:0]   Lock;
  logic [N*W-1:0] Data;
  logic [N-1:0]   Ack;
  logic [N-1:0]   Grant;
  logic           TxEmpty;
  logic           XMitGo;
  logic [W-1:0]   TxData;
  logic           Busy;
  logic           Timeout;

  modport master (
    output Req, Lock, Data, TxEmpty,
    input  Ack, Grant, XMitGo, TxData, Busy, Timeout
  );

  modport slave (
    input  Req, Lock, Data, TxEmpty,
    output Ack, Grant, XMitGo, TxData, Busy, Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock that sequences bytes from N producers into one UART_TX.
// Start is held until TxEmpty falls, then completion is awaited; either phase aborts after TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input logic           Clock,
  input logic           Reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           lock_vld_q, lock_vld_d;
  logic [PW-1:0]  lock_id_q, lock_id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           xmit_q, xmit_d;
  logic [W-1:0]   txdata_q, txdata_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;

  logic           win_vld;
  logic [PW-1:0]  win_id;
  logic [N-1:0]   win_oh;

  // A live lock owner beats the round-robin scan starting at ptr_q.
  always_comb begin
    int unsigned   idx;
    logic [PW-1:0] cand;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    cand    = '0;
    if (lock_vld_q && bus.Req[lock_id_q]) begin
      win_vld = 1'b1;
      win_id  = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx  = (32'(ptr_q) + k) % N;
        cand = PW'(idx);
        if (!win_vld && bus.Req[cand]) begin
          win_vld = 1'b1;
          win_id  = cand;
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      win_oh[i] = (PW'(i) == win_id);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    grant_d    = grant_q;
    xmit_d     = xmit_q;
    txdata_d   = txdata_q;
    busy_d     = busy_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (lock_vld_q && !bus.Req[lock_id_q]) lock_vld_d = 1'b0;
        if (bus.TxEmpty && win_vld) begin
          txdata_d   = bus.Data[win_id*W +: W];
          ack_d      = win_oh;
          grant_d    = win_oh;
          xmit_d     = 1'b1;
          busy_d     = 1'b1;
          ptr_d      = PW'((32'(win_id) + 1) % N);
          lock_vld_d = bus.Lock[win_id];
          lock_id_d  = win_id;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START, BUSY: begin
        if (state_q == START && !bus.TxEmpty) begin
          xmit_d  = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end else if (state_q == BUSY && bus.TxEmpty) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort drops the already-acked byte and forgets any lock.
          tmo_d      = 1'b1;
          xmit_d     = 1'b0;
          grant_d    = '0;
          busy_d     = 1'b0;
          lock_vld_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      xmit_q     <= 1'b0;
      txdata_q   <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      xmit_q     <= xmit_d;
      txdata_q   <= txdata_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.Ack     = ack_q;
  assign bus.Grant   = grant_q;
  assign bus.XMitGo  = xmit_q;
  assign bus.TxData  = txdata_q;
  assign bus.Busy    = busy_q;
  assign bus.Timeout = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a per-transaction reference model checked every cycle,
// directed scenarios with literal expectations, then randomized producers and transmitter.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arbiter_if #(.N(N), .W(W)) bus ();

  uart_tx_arbiter #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input int v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  // Reference model: one outstanding byte at a time, described by who owns the
  // transmitter, whether the UART has taken it, and how long this phase has lasted.
  int             m_owner, m_ptr, m_lock, m_age;
  bit             m_sent;
  logic [N-1:0]   e_ack, e_grant;
  logic           e_xmit, e_busy, e_tmo;
  logic [W-1:0]   e_txd;

  task automatic model_abort();
    e_tmo = 1'b1; e_xmit = 1'b0; e_grant = '0; e_busy = 1'b0;
    m_lock = -1; m_owner = -1;
  endtask

  always @(posedge clk or posedge rst) begin
    int r, w;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_lock = -1; m_age = 0; m_sent = 0;
      e_ack = '0; e_grant = '0; e_xmit = 1'b0; e_busy = 1'b0; e_tmo = 1'b0; e_txd = '0;
    end else begin
      r = int'(bus.Req);
      e_ack = '0;
      if (m_owner < 0) begin
        if (m_lock >= 0 && !bit_of(r, m_lock)) m_lock = -1;
        if (bus.TxEmpty && r != 0) begin
          w = -1;
          if (m_lock >= 0) w = m_lock;
          else for (int k = 0; k < N; k++)
            if (w < 0 && bit_of(r, (m_ptr + k) % N)) w = (m_ptr + k) % N;
          e_txd   = W'(bus.Data >> (w * W));
          e_ack   = N'(1 << w);
          e_grant = N'(1 << w);
          e_xmit  = 1'b1;
          e_busy  = 1'b1;
          m_ptr   = (w + 1) % N;
          m_lock  = bit_of(int'(bus.Lock), w) ? w : -1;
          m_owner = w; m_sent = 0; m_age = 0;
        end
      end else if (!m_sent) begin
        if (!bus.TxEmpty) begin m_sent = 1; m_age = 0; e_xmit = 1'b0; end
        else if (m_age == TMO - 1) model_abort();
        else m_age++;
      end else begin
        if (bus.TxEmpty) begin m_owner = -1; e_grant = '0; e_busy = 1'b0; end
        else if (m_age == TMO - 1) model_abort();
        else m_age++;
      end
    end
  end

  always @(negedge clk) begin
    check("ack",     32'(bus.Ack),     32'(e_ack));
    check("grant",   32'(bus.Grant),   32'(e_grant));
    check("xmitgo",  32'(bus.XMitGo),  32'(e_xmit));
    check("txdata",  32'(bus.TxData),  32'(e_txd));
    check("busy",    32'(bus.Busy),    32'(e_busy));
    check("timeout", 32'(bus.Timeout), 32'(e_tmo));
    for (int i = 0; i < N; i++) if (bit_of(int'(bus.Ack), i)) ack_log.push_back(i);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    bus.Data = (bus.Data & ~((N*W)'({W{1'b1}}) << (i * W))) | ((N*W)'(v) << (i * W));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Req = '0; bus.Lock = '0; bus.TxEmpty = 1'b1;
    step(2);
    rst = 1'b0;
    ack_log.delete();
  endtask

  task automatic wait_xmit();
    bit ok;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.XMitGo) begin ok = 1; break; end
      step(1);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL xmit_wait: got no XMitGo within 50 cycles, required one at %0t", $time);
    end
  endtask

  task automatic finish_byte();
    bus.TxEmpty = 1'b0;
    step(3);
    bus.TxEmpty = 1'b1;
    step(1);
  endtask

  task automatic check_order(input string name, input int exp[5]);
    check({name, "_len"}, 32'(ack_log.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < ack_log.size()) check(name, 32'(ack_log[k]), 32'(exp[k]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int rq, lk;
    bus.Data = '0;
    do_reset();

    // Reset state
    check("rst_ack", 32'(bus.Ack), 0);
    check("rst_grant", 32'(bus.Grant), 0);
    check("rst_xmit", 32'(bus.XMitGo), 0);
    check("rst_txdata", 32'(bus.TxData), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_timeout", 32'(bus.Timeout), 0);

    // Single byte
    set_slice(0, 8'h55);
    bus.Req = 4'b0001;
    step(1);
    check("sb_ack", 32'(bus.Ack), 32'h1);
    check("sb_grant", 32'(bus.Grant), 32'h1);
    check("sb_txdata", 32'(bus.TxData), 32'h55);
    check("sb_xmit", 32'(bus.XMitGo), 32'h1);
    bus.Req = '0;
    step(3);
    bus.TxEmpty = 1'b0;
    step(1);
    check("sb_xmit_low", 32'(bus.XMitGo), 0);
    check("sb_grant_held", 32'(bus.Grant), 32'h1);
    bus.TxEmpty = 1'b1;
    step(1);
    check("sb_grant_off", 32'(bus.Grant), 0);
    check("sb_busy_off", 32'(bus.Busy), 0);

    // Round robin
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, 8'(8'hA0 + i));
    bus.Req = 4'b1111;
    for (int j = 0; j < 5; j++) begin wait_xmit(); finish_byte(); end
    bus.Req = '0;
    check_order("rr_order", '{0, 1, 2, 3, 0});

    // Lock burst, pointer moved to 1 by a first byte from requester 0
    do_reset();
    bus.Req = 4'b0001;
    wait_xmit();
    bus.Req = '0;
    finish_byte();
    ack_log.delete();
    bus.Req = 4'b0011;
    for (int j = 0; j < 5; j++) begin
      bus.Lock = (j < 3) ? 4'b0010 : 4'b0000;
      wait_xmit();
      finish_byte();
    end
    bus.Req = '0; bus.Lock = '0;
    check_order("lock_order", '{1, 1, 1, 1, 0});

    // Transmitter busy when the request arrives
    do_reset();
    bus.TxEmpty = 1'b0;
    set_slice(2, 8'h3C);
    bus.Req = 4'b0100;
    for (int j = 0; j < 5; j++) begin step(1); check("bt_no_ack", 32'(bus.Ack), 0); end
    bus.TxEmpty = 1'b1;
    step(1);
    check("bt_ack", 32'(bus.Ack), 32'h4);
    check("bt_txdata", 32'(bus.TxData), 32'h3C);
    bus.Req = '0;
    finish_byte();

    // Timeout with a transmitter that never starts
    do_reset();
    bus.Req = 4'b0001;
    step(1);
    bus.Req = '0;
    step(TMO - 1);
    check("to_not_yet", 32'(bus.Timeout), 0);
    check("to_xmit_held", 32'(bus.XMitGo), 32'h1);
    step(1);
    check("to_flag", 32'(bus.Timeout), 32'h1);
    check("to_xmit", 32'(bus.XMitGo), 0);
    check("to_grant", 32'(bus.Grant), 0);
    bus.Req = 4'b0010;
    step(1);
    check("to_next_ack", 32'(bus.Ack), 32'h2);
    check("to_sticky", 32'(bus.Timeout), 32'h1);
    bus.Req = '0;
    finish_byte();

    // Asynchronous reset while BUSY, pointer left at 2 beforehand
    do_reset();
    set_slice(1, 8'hA5);
    bus.Req = 4'b0010;
    step(1);
    bus.Req = '0;
    bus.TxEmpty = 1'b0;
    step(2);
    #2 rst = 1'b1;
    #1;
    check("ar_ack", 32'(bus.Ack), 0);
    check("ar_grant", 32'(bus.Grant), 0);
    check("ar_xmit", 32'(bus.XMitGo), 0);
    check("ar_txdata", 32'(bus.TxData), 0);
    check("ar_busy", 32'(bus.Busy), 0);
    step(1);
    rst = 1'b0;
    bus.TxEmpty = 1'b1;
    bus.Req = 4'b0101;
    step(1);
    check("ar_ptr_restart", 32'(bus.Ack), 32'h1);
    bus.Req = 4'b0100;
    finish_byte();
    wait_xmit();
    check("ar_grant2", 32'(bus.Grant), 32'h4);
    bus.Req = '0;
    finish_byte();

    // Randomized producers, locks and transmitter
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rq = int'(bus.Req);
      for (int i = 0; i < N; i++) begin
        if (bit_of(rq, i) && !bit_of(int'(bus.Ack), i)) begin
          if ($urandom_range(0, 7) == 0) rq = rq & ~(1 << i);
        end else begin
          rq = rq & ~(1 << i);
          if ($urandom_range(0, 1) == 1) begin
            rq = rq | (1 << i);
            set_slice(i, 8'($urandom));
          end
        end
      end
      bus.Req = N'(rq);
      lk = int'($urandom_range(0, 15));
      bus.Lock = N'(lk);
      if ($urandom_range(0, 2) == 0) bus.TxEmpty = ~bus.TxEmpty;
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
